// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes ({g,f,e,d,c,b,a})
// and the scan digit-index type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes
// show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode display driver with frame snapshot,
// leading-zero blanking, per-digit blink and decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 2700,
  parameter int unsigned BLINK_DIV = 9000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(2 * BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  digit_idx_t         idx;
  logic [15:0]        sh_digits;
  logic [3:0]         sh_dp;

  logic        tick;
  logic        snap;
  digit_idx_t  idx_nxt;
  logic [15:0] dig_nxt;
  logic [3:0]  dp_nxt;
  logic [3:0]  code;
  logic [6:0]  seg_dec;
  logic        blank;
  logic        phase_on;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_n_nxt;
  logic        z3, z2, z1;

  // Outputs are built from the post-tick index and shadow so a new snapshot
  // appears on the very edge that captures it.
  always_comb begin
    tick     = (scan_cnt == SCAN_LAST);
    snap     = (idx == 2'd3);
    idx_nxt  = idx + 2'd1;
    dig_nxt  = snap ? digits : sh_digits;
    dp_nxt   = snap ? dp : sh_dp;
    code     = dig_nxt[{idx_nxt, 2'b00} +: 4];
    z3       = (dig_nxt[15:12] == 4'd0);
    z2       = (dig_nxt[11:8] == 4'd0);
    z1       = (dig_nxt[7:4] == 4'd0);
    blank    = 1'b0;
    case (idx_nxt)
      2'd3:    blank = blank_lz & z3;
      2'd2:    blank = blank_lz & z3 & z2;
      2'd1:    blank = blank_lz & z3 & z2 & z1;
      default: blank = 1'b0;
    endcase
    phase_on = (blink_cnt < BLINK_HALF);
    an_nxt   = (blink_mask[idx_nxt] && !phase_on) ? 4'b1111 : ~(4'b0001 << idx_nxt);
    seg_nxt  = blank ? SEG_BLANK : seg_dec;
    dp_n_nxt = blank ? 1'b1 : ~dp_nxt[idx_nxt];
  end

  seg7_decode u_decode (
    .code (code),
    .seg  (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= 2'd3;
      sh_digits <= '0;
      sh_dp     <= '0;
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
      dp_n      <= 1'b1;
      frame     <= 1'b0;
    end else begin
      scan_cnt  <= tick ? '0 : scan_cnt + 1'b1;
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      frame     <= tick & snap;
      if (tick) begin
        idx  <= idx_nxt;
        an   <= an_nxt;
        seg  <= seg_nxt;
        dp_n <= dp_n_nxt;
        if (snap) begin
          sh_digits <= digits;
          sh_dp     <= dp;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with SCAN_DIV=4, BLINK_DIV=32.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  seg7_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;   // index = slot
    logic [3:0]      dpn;   // bit = slot
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } exp_t;

  localparam exp_t RESET_OUT = '{an: 4'b1111, seg: 7'h7F, dp_n: 1'b1};

  vec_t vecs [8];
  exp_t q [$];
  exp_t last;
  int   n;
  int   tests = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at n=%0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int unsigned s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    chk("frame", 16'(frame), 16'(n % 16 == 4));
    if (n % 4 == 0) begin
      if (q.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL scoreboard at n=%0d: got empty queue expected a slot record", n);
      end else begin
        last = q.pop_front();
      end
    end
    chk("an", 16'(an), 16'(last.an));
    chk("seg", 16'(seg), 16'(last.seg));
    chk("dp_n", 16'(dp_n), 16'(last.dp_n));
  endtask

  task automatic drive(input vec_t v, input logic [3:0] mask);
    digits     = v.digits;
    dp         = v.dp;
    blank_lz   = v.lz;
    blink_mask = mask;
  endtask

  task automatic push_frame(input vec_t v);
    for (int unsigned s = 0; s < 4; s++)
      q.push_back('{an: an_of(s), seg: v.seg[s], dp_n: v.dpn[s]});
  endtask

  task automatic check_reset_out();
    chk("rst_an", 16'(an), 16'(4'b1111));
    chk("rst_seg", 16'(seg), 16'(7'h7F));
    chk("rst_dp_n", 16'(dp_n), 16'(1'b1));
    chk("rst_frame", 16'(frame), 16'(1'b0));
  endtask

  initial begin
    vec_t v;
    exp_t e;
    vecs[0] = '{16'h1234, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
    vecs[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h00A5, 4'b0000, 1'b0, {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010010}, 4'b1111};
    vecs[4] = '{16'h00A5, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'b0111111, 7'b0010010}, 4'b1111};
    vecs[5] = '{16'h0800, 4'b1111, 1'b1, {7'h7F, 7'b0000000, 7'b1000000, 7'b1000000}, 4'b1000};
    vecs[6] = '{16'h9F6E, 4'b1010, 1'b1, {7'b0010000, 7'b0111111, 7'b0000010, 7'b0111111}, 4'b0101};
    vecs[7] = '{16'h0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1110};

    reset = 1'b1;
    drive(vecs[0], 4'b0000);
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_out();
    reset = 1'b0;
    n = 0;
    last = RESET_OUT;

    // Table vectors, one frame each; first frame also covers first tick at edge 4.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i], 4'b0000);
      push_frame(vecs[i]);
      repeat (16) step();
    end

    // Mid-frame digit change is held off until the next frame.
    v = '{16'h1111, 4'b0000, 1'b0, {4{7'b1111001}}, 4'b1111};
    drive(v, 4'b0000);
    push_frame(v);
    repeat (9) step();
    v = '{16'h2222, 4'b0000, 1'b0, {4{7'b0100100}}, 4'b1111};
    drive(v, 4'b0000);
    push_frame(v);
    repeat (7) step();
    repeat (16) step();

    // Blink on digit 0 across one full blink period.
    for (int f = 0; f < 4; f++) begin
      drive(vecs[0], 4'b0001);
      push_frame(vecs[0]);
      if (((n + 3) % 64) >= 32) begin
        e = q[q.size() - 4];
        e.an = 4'b1111;
        q[q.size() - 4] = e;
      end
      repeat (16) step();
    end

    // Reset asserted while slot 2 is lit.
    drive(vecs[3], 4'b0000);
    push_frame(vecs[3]);
    repeat (13) step();
    reset = 1'b1;
    #1;
    check_reset_out();
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_out();
    reset = 1'b0;
    n = 0;
    last = RESET_OUT;
    push_frame(vecs[3]);
    repeat (16) step();

    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
